rom_load_sequencer: RTL and testbench

- Sits between the hps_io download port and the ultra_tank core's dn_addr/dn_data/dn_wr ROM-load port.
- Sequences a complete ROM download: validates sequential addressing and total length, registers the write path, and decodes the target ROM region.
- Owns the core's reset. The core is held in reset until a verified image is loaded, and for RST_HOLD cycles after any reset request.

---
 rtl/rom_load_sequencer.sv | 173 +++++++++++++++++
 tb/tb_rom_load_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer
//   Bridges the hps_io download port to the core's ROM-load port. It checks
//   that bytes arrive strictly in order from address 0, that the image length
//   is exactly TOTAL_BYTES, forwards accepted bytes one cycle later, and tags
//   each forwarded byte with its one-hot ROM region. It also owns the core
//   reset: the core stays in reset until a verified image is loaded, and for
//   RST_HOLD cycles after a good load or a user reset request.
//
// Ports
//   clk_sys, reset        : system clock, async active-high reset
//   user_reset            : level reset request (OSD / button)
//   ioctl_download        : download active level
//   ioctl_wr              : one-cycle byte strobe
//   ioctl_addr/ioctl_dout : byte address / byte data
//   dn_addr/dn_data/dn_wr : registered write port to the core
//   region_sel            : one-hot region of dn_addr, valid with dn_wr
//   core_reset_n          : registered active-low core reset
//   rom_ok / rom_err      : result of the last download
//   byte_cnt              : bytes accepted in the current/last download
module rom_load_sequencer #(
    parameter logic [15:0] TOTAL_BYTES = 16'h2000,
    parameter int unsigned RST_HOLD    = 16,
    parameter logic [15:0] REG1_BASE   = 16'h0800,
    parameter logic [15:0] REG2_BASE   = 16'h1000,
    parameter logic [15:0] REG3_BASE   = 16'h1800
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        user_reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic [3:0]  region_sel,
    output logic        core_reset_n,
    output logic        rom_ok,
    output logic        rom_err,
    output logic [15:0] byte_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

    localparam logic [15:0] HOLD_LAST = 16'(RST_HOLD - 1);

    state_t      state_q;
    logic        dl_q;
    logic [15:0] dn_addr_q;
    logic [7:0]  dn_data_q;
    logic        dn_wr_q;
    logic [3:0]  region_q;
    logic        core_rst_n_q;
    logic        rom_ok_q;
    logic        rom_err_q;
    logic [15:0] byte_cnt_q;
    logic [15:0] hold_q;

    logic        dl_rise;
    logic        dl_fall;
    logic        addr_in_range;
    logic        wr_ok;
    logic        wr_bad;
    logic [15:0] byte_cnt_d;
    logic        rom_err_d;
    logic [3:0]  region_dec;

    assign dl_rise = ioctl_download & ~dl_q;
    assign dl_fall = ~ioctl_download & dl_q;

    // Any address bit above 15 set means the address is beyond the image.
    assign addr_in_range = (ioctl_addr[24:16] == 9'd0) && (ioctl_addr[15:0] < TOTAL_BYTES);

    // Once an error is latched, later strobes neither write nor re-flag.
    assign wr_ok  = (state_q == LOAD) && ioctl_wr && !rom_err_q && addr_in_range &&
                    (ioctl_addr[15:0] == byte_cnt_q);
    assign wr_bad = (state_q == LOAD) && ioctl_wr && !rom_err_q && !wr_ok;

    // Values after this cycle's write; the end-of-download length check uses
    // these so a write coinciding with the falling edge still counts.
    assign byte_cnt_d = byte_cnt_q + {15'd0, wr_ok};
    assign rom_err_d  = rom_err_q | wr_bad;

    always_comb begin
        region_dec = 4'b1000;
        if (ioctl_addr[15:0] < REG1_BASE)      region_dec = 4'b0001;
        else if (ioctl_addr[15:0] < REG2_BASE) region_dec = 4'b0010;
        else if (ioctl_addr[15:0] < REG3_BASE) region_dec = 4'b0100;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            // Treat the download line as already high so a download that is
            // still active when reset releases is not picked up mid-stream.
            dl_q         <= 1'b1;
            dn_addr_q    <= '0;
            dn_data_q    <= '0;
            dn_wr_q      <= 1'b0;
            region_q     <= '0;
            core_rst_n_q <= 1'b0;
            rom_ok_q     <= 1'b0;
            rom_err_q    <= 1'b0;
            byte_cnt_q   <= '0;
            hold_q       <= '0;
        end else begin
            dl_q     <= ioctl_download;
            dn_wr_q  <= 1'b0;
            region_q <= '0;
            if (wr_ok) begin
                dn_wr_q   <= 1'b1;
                dn_addr_q <= ioctl_addr[15:0];
                dn_data_q <= ioctl_dout;
                region_q  <= region_dec;
            end
            if (dl_rise) begin
                state_q      <= LOAD;
                byte_cnt_q   <= '0;
                rom_ok_q     <= 1'b0;
                rom_err_q    <= 1'b0;
                core_rst_n_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: core_rst_n_q <= 1'b0;
                    LOAD: begin
                        byte_cnt_q <= byte_cnt_d;
                        rom_err_q  <= rom_err_d;
                        if (dl_fall) begin
                            if (!rom_err_d && (byte_cnt_d == TOTAL_BYTES)) begin
                                rom_ok_q <= 1'b1;
                                hold_q   <= '0;
                                state_q  <= HOLD;
                            end else begin
                                rom_err_q <= 1'b1;
                                state_q   <= IDLE;
                            end
                        end
                    end
                    HOLD: begin
                        core_rst_n_q <= 1'b0;
                        if (user_reset) begin
                            hold_q <= '0;
                        end else if (hold_q == HOLD_LAST) begin
                            core_rst_n_q <= 1'b1;
                            state_q      <= RUN;
                        end else begin
                            hold_q <= hold_q + 16'd1;
                        end
                    end
                    RUN: begin
                        if (user_reset) begin
                            core_rst_n_q <= 1'b0;
                            hold_q       <= '0;
                            state_q      <= HOLD;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign dn_addr      = dn_addr_q;
    assign dn_data      = dn_data_q;
    assign dn_wr        = dn_wr_q;
    assign region_sel   = region_q;
    assign core_reset_n = core_rst_n_q;
    assign rom_ok       = rom_ok_q;
    assign rom_err      = rom_err_q;
    assign byte_cnt     = byte_cnt_q;

endmodule

// File: tb/tb_rom_load_sequencer.sv
module tb_rom_load_sequencer;
    logic        clk_sys = 1'b0;
    logic        reset, user_reset, ioctl_download, ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] dn_addr, byte_cnt;
    logic [7:0]  dn_data;
    logic        dn_wr, core_reset_n, rom_ok, rom_err;
    logic [3:0]  region_sel;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: bytes accepted so far and whether an error was seen
    int m_cnt;
    bit m_err;

    localparam int IMG = 8192;

    always #5 clk_sys = ~clk_sys;

    rom_load_sequencer dut (
        .clk_sys(clk_sys), .reset(reset), .user_reset(user_reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
        .region_sel(region_sel), .core_reset_n(core_reset_n),
        .rom_ok(rom_ok), .rom_err(rom_err), .byte_cnt(byte_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    function automatic logic [3:0] region_of(input int a);
        if (a < 'h800)  return 4'b0001;
        if (a < 'h1000) return 4'b0010;
        if (a < 'h1800) return 4'b0100;
        return 4'b1000;
    endfunction

    // One byte strobe; optionally drops ioctl_download in the same cycle.
    task automatic wr_byte(input logic [24:0] a, input bit drop);
        bit acc;
        logic [7:0] d;
        d = 8'($urandom);
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
        if (drop) ioctl_download = 1'b0;
        acc = !m_err && (a == 25'(m_cnt)) && (a < 25'(IMG));
        tick;
        ioctl_wr = 1'b0;
        chk("dn_wr", 32'(dn_wr), 32'(acc));
        if (acc) begin
            chk("dn_addr", 32'(dn_addr), 32'(a));
            chk("dn_data", 32'(dn_data), 32'(d));
            chk("region_sel", 32'(region_sel), 32'(region_of(int'(a))));
            m_cnt++;
        end else begin
            m_err = 1'b1;
        end
        chk("byte_cnt", 32'(byte_cnt), 32'(m_cnt));
        if (!drop && $urandom_range(3) == 0) begin
            tick;
            chk("dn_wr_gap", 32'(dn_wr), 0);
        end
    endtask

    task automatic end_check;
        bit good;
        good = !m_err && (m_cnt == IMG);
        chk("rom_ok", 32'(rom_ok), 32'(good));
        chk("rom_err", 32'(rom_err), 32'(!good));
        chk("byte_cnt_end", 32'(byte_cnt), 32'(m_cnt));
        chk("core_rst_end", 32'(core_reset_n), 0);
        if (good) begin
            for (int i = 1; i <= 16; i++) begin
                tick;
                chk("core_rst_hold", 32'(core_reset_n), 32'(i == 16));
            end
        end else begin
            for (int i = 0; i < 20; i++) begin
                ioctl_wr = 1'($urandom_range(1));
                ioctl_addr = 25'(m_cnt);
                tick;
                chk("core_rst_idle", 32'(core_reset_n), 0);
                chk("dn_wr_idle", 32'(dn_wr), 0);
            end
            ioctl_wr = 1'b0;
        end
    endtask

    // n strobes at addresses 0..n-1, except strobe bad_at uses bad_addr.
    task automatic download(input int n, input int bad_at, input logic [24:0] bad_addr, input bit sim_end);
        logic [24:0] a;
        ioctl_download = 1'b1;
        tick;
        m_cnt = 0; m_err = 1'b0;
        chk("start_cnt", 32'(byte_cnt), 0);
        chk("start_ok", 32'(rom_ok), 0);
        chk("start_err", 32'(rom_err), 0);
        chk("start_core_rst", 32'(core_reset_n), 0);
        for (int i = 0; i < n; i++) begin
            a = (i == bad_at) ? bad_addr : 25'(i);
            wr_byte(a, sim_end && (i == n - 1));
        end
        if (!sim_end || n == 0) begin
            ioctl_download = 1'b0;
            tick;
        end
        end_check();
    endtask

    initial begin
        int n, k, kind;
        reset = 1'b1; user_reset = 1'b0; ioctl_download = 1'b0;
        ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
        tick; tick;
        chk("rst_dn_wr", 32'(dn_wr), 0);
        chk("rst_core", 32'(core_reset_n), 0);
        chk("rst_ok", 32'(rom_ok), 0);
        chk("rst_err", 32'(rom_err), 0);
        chk("rst_cnt", 32'(byte_cnt), 0);
        chk("rst_region", 32'(region_sel), 0);
        reset = 1'b0;
        ioctl_wr = 1'b1;
        tick;
        ioctl_wr = 1'b0;
        chk("idle_wr_ignored", 32'(dn_wr), 0);
        chk("idle_core", 32'(core_reset_n), 0);

        // clean load, ends after last write
        download(IMG, -1, '0, 1'b0);

        // in RUN: stray write, then user reset
        ioctl_wr = 1'b1;
        tick;
        ioctl_wr = 1'b0;
        chk("run_wr_ignored", 32'(dn_wr), 0);
        chk("run_core", 32'(core_reset_n), 1);
        user_reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("ureset_core", 32'(core_reset_n), 0);
            chk("ureset_dn_wr", 32'(dn_wr), 0);
        end
        user_reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick;
            chk("ureset_release", 32'(core_reset_n), 32'(i == 16));
            chk("ureset_dn_wr", 32'(dn_wr), 0);
        end

        // overflow past the image, then short image
        download(IMG + 1, IMG, 25'h2000, 1'b0);
        download(IMG - 1, -1, '0, 1'b0);
        // gap, repeat, high address bits
        download(20, 10, 25'd11, 1'b0);
        download(20, 7, 25'd6, 1'b1);
        download(8, 0, 25'h10000, 1'b0);

        // randomized short downloads with random faults
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 200);
            k = $urandom_range(0, n - 1);
            kind = $urandom_range(0, 3);
            case (kind)
                0: download(n, -1, '0, 1'($urandom_range(1)));
                1: download(n, k, 25'(k + 1 + $urandom_range(3)), 1'($urandom_range(1)));
                2: download(n, k, 25'(k) | 25'(1 << $urandom_range(16, 24)), 1'b0);
                default: download(n, k, 25'(IMG + $urandom_range(100)), 1'($urandom_range(1)));
            endcase
        end

        // async reset in the middle of a download
        ioctl_download = 1'b1;
        tick;
        m_cnt = 0; m_err = 1'b0;
        for (int i = 0; i < 100; i++) wr_byte(25'(i), 1'b0);
        ioctl_wr = 1'b1; ioctl_addr = 25'd100;
        #2 reset = 1'b1;
        #1;
        chk("areset_dn_wr", 32'(dn_wr), 0);
        chk("areset_dn_addr", 32'(dn_addr), 0);
        chk("areset_dn_data", 32'(dn_data), 0);
        chk("areset_region", 32'(region_sel), 0);
        chk("areset_cnt", 32'(byte_cnt), 0);
        chk("areset_ok", 32'(rom_ok), 0);
        chk("areset_err", 32'(rom_err), 0);
        chk("areset_core", 32'(core_reset_n), 0);
        tick;
        chk("areset_dn_wr_edge", 32'(dn_wr), 0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ioctl_addr = 25'(i);
            tick;
            chk("no_resume_dn_wr", 32'(dn_wr), 0);
            chk("no_resume_cnt", 32'(byte_cnt), 0);
        end
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        tick;

        // fresh clean load, final byte coincides with download end
        download(IMG, -1, '0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
